johnson_step_sequencer: RTL and testbench
=========================================

# johnson_step_sequencer

Command-driven controller that sequences a WIDTH-bit Johnson counter as a multi-phase drive pattern for a stepper-style load. Accepts a command with step count, direction and step period through a valid/ready handshake, then advances the Johnson pattern forward or backward once per period. Signals completion with a one-cycle pulse. Sits between the control/register layer and the phase drivers; the pattern position is retained between commands.

## Interface
- WIDTH, 4: Johnson pattern width; 2*WIDTH legal states; WIDTH >= 2
- CNT_W, 16: width of step count
- DIV_W, 12: width of step period
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high when IDLE; a command is accepted on an edge where cmd_valid && cmd_ready
- cmd_dir  in  1  1 = forward, 0 = reverse
- cmd_steps  in  CNT_W  number of steps, unsigned
- cmd_period  in  DIV_W  step interval minus 1, in clk cycles
- out_j  out  WIDTH  registered Johnson drive pattern
- step_pulse  out  1  registered, high for one cycle in the cycle out_j takes a new value
- done  out  1  registered, one-cycle completion pulse
- busy  out  1  equals ~cmd_ready
- steps_left  out  CNT_W  registered remaining step count

## Operation
- FSM states: IDLE, RUN.
- IDLE: cmd_ready=1. On accept:
  - cmd_steps==0: remain in IDLE; done=1 for the next cycle; out_j unchanged.
  - Otherwise latch dir/period; steps_left<=cmd_steps; divider<=cmd_period; go to RUN.
- RUN: the divider decrements each cycle. When divider==0:
  - Advance out_j one step and set step_pulse for that cycle.
  - Decrement steps_left and reload the divider with the latched period.
  - If steps_left was 1: go to IDLE and set done in the same cycle as the final step_pulse.
- Forward step: out_j <= {out_j[WIDTH-2:0], ~out_j[WIDTH-1]}.
  - Sequence from 0000 for WIDTH=4: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
- Reverse step: out_j <= {~out_j[0], out_j[WIDTH-1:1]}.
  - Sequence from 0000: 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
- The pattern wraps naturally after 2*WIDTH steps; there is no end stop.
- cmd_* inputs are ignored while in RUN; cmd_dir/cmd_period changes mid-command have no effect.
- Reset values: out_j=0, step_pulse=0, done=0, steps_left=0, divider=0, FSM=IDLE (cmd_ready=1, busy=0).
- Reset mid-RUN: abandons the command, returns out_j to 0, and generates no done pulse.

## Timing
- Command accepted at edge k:
  - First out_j change and step_pulse at edge k+cmd_period+1.
  - Subsequent steps every cmd_period+1 cycles.
- Total command duration is cmd_steps*(cmd_period+1) cycles from acceptance to the final step.
- cmd_period=0 steps every cycle.
- cmd_ready rises in the same cycle as done. The earliest next command is accepted on the following edge, giving back-to-back commands with no idle gap beyond one cycle.
- done, step_pulse and out_j are all registered outputs with no combinational path from cmd_* inputs.
- cmd_ready and busy are combinational from FSM state only.

## Configuration
- JSEQ_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort high in RUN forces IDLE on the next edge and suppresses any step due that edge; abort wins over a simultaneous step.
  - Adds output aborted (1 bit, registered), which pulses one cycle in the cycle FSM returns to IDLE; done is not asserted.
  - steps_left holds the unexecuted count; out_j holds its current value.
  - abort in IDLE is ignored.
- JSEQ_ABORT_EN undefined: abort and aborted ports are absent; every accepted command runs to completion or reset.

## Test plan
- Reset, then forward steps=8 with period=0 from out_j=0000 -> out_j visits 0001..0000 on 8 consecutive cycles; done coincident with the 8th step_pulse; final out_j=0000.
- Forward steps=3 with period=4, then reverse steps=3 with period=4 -> step_pulse spacing is 5 cycles; out_j goes to 0111 then back to 0000; busy is low 1 cycle between the two commands.
- steps=0 -> no step_pulse; done for one cycle after acceptance; cmd_ready stays high.
- Forward steps=10, period=2, with cmd_valid held and inputs changed mid-run -> exactly 10 steps at 3-cycle spacing; out_j=0011 (10 mod 8 = 2); no second acceptance until cmd_ready rises.
- rst asserted mid-run after 3 steps -> next cycle out_j=0, steps_left=0, cmd_ready=1, no done.
- With JSEQ_ABORT_EN: abort on the same cycle a step is due at steps_left=5 -> no step; aborted pulses; steps_left=5; done stays 0.

Source files
------------

// File: rtl/johnson_step_sequencer.sv
// johnson_step_sequencer
// Command-driven Johnson-counter stepper. A command (steps, direction,
// period) is accepted over a valid/ready handshake. The WIDTH-bit Johnson
// pattern then advances once every period+1 cycles until the step count
// is exhausted. The pattern position is kept between commands.
// Optional build macro: JSEQ_ABORT_EN adds an abort input and an aborted
// pulse output that cancel a running command without a done pulse.
module johnson_step_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 16,
   parameter int DIV_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0] cmd_period,
   output logic [WIDTH-1:0] out_j,
   output logic             step_pulse,
   output logic             done,
   output logic             busy,
`ifdef JSEQ_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic [CNT_W-1:0] steps_left
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] out_j_q;
   logic [WIDTH-1:0] out_j_d;
   logic [CNT_W-1:0] steps_left_q;
   logic [DIV_W-1:0] divider_q;
   logic [DIV_W-1:0] period_q;
   logic             dir_q;
   logic             step_pulse_q;
   logic             done_q;
`ifdef JSEQ_ABORT_EN
   logic             aborted_q;
`endif

   // Pattern one step further along in the latched direction
   always_comb begin
      out_j_d = out_j_q;
      if (dir_q) begin
         out_j_d = {out_j_q[WIDTH-2:0], ~out_j_q[WIDTH-1]};
      end else begin
         out_j_d = {~out_j_q[0], out_j_q[WIDTH-1:1]};
      end
   end

   // Command FSM: accept in IDLE, count the divider down and step in RUN
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         out_j_q      <= '0;
         steps_left_q <= '0;
         divider_q    <= '0;
         period_q     <= '0;
         dir_q        <= 1'b0;
         step_pulse_q <= 1'b0;
         done_q       <= 1'b0;
`ifdef JSEQ_ABORT_EN
         aborted_q    <= 1'b0;
`endif
      end else begin
         // Pulses default low; only the cases below raise them for a cycle
         step_pulse_q <= 1'b0;
         done_q       <= 1'b0;
`ifdef JSEQ_ABORT_EN
         aborted_q    <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_steps == '0) begin
                     // Empty command completes immediately, pattern untouched
                     done_q <= 1'b1;
                  end else begin
                     dir_q        <= cmd_dir;
                     period_q     <= cmd_period;
                     divider_q    <= cmd_period;
                     steps_left_q <= cmd_steps;
                     state_q      <= RUN;
                  end
               end
            end
            RUN: begin
               if (divider_q == '0) begin
                  out_j_q      <= out_j_d;
                  step_pulse_q <= 1'b1;
                  steps_left_q <= steps_left_q - CNT_W'(1);
                  divider_q    <= period_q;
                  if (steps_left_q == CNT_W'(1)) begin
                     // Final step: done coincides with the last step pulse
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  divider_q <= divider_q - DIV_W'(1);
               end
`ifdef JSEQ_ABORT_EN
               // Abort overrides any step due this edge; later NBAs win
               if (abort) begin
                  state_q      <= IDLE;
                  aborted_q    <= 1'b1;
                  out_j_q      <= out_j_q;
                  steps_left_q <= steps_left_q;
                  divider_q    <= divider_q;
                  step_pulse_q <= 1'b0;
                  done_q       <= 1'b0;
               end
`endif
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = ~cmd_ready;
   assign out_j      = out_j_q;
   assign step_pulse = step_pulse_q;
   assign done       = done_q;
   assign steps_left = steps_left_q;
`ifdef JSEQ_ABORT_EN
   assign aborted    = aborted_q;
`endif

endmodule

// File: tb/tb_johnson_step_sequencer.sv
// Testbench for johnson_step_sequencer. The reference model tracks the
// pattern as an integer position modulo 2*WIDTH and derives step times
// arithmetically from the acceptance cycle.
module tb_johnson_step_sequencer;

   localparam int W     = 4;
   localparam int CNT_W = 16;
   localparam int DIV_W = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic             cmd_valid;
   logic             cmd_ready;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_steps;
   logic [DIV_W-1:0] cmd_period;
   logic [W-1:0]     out_j;
   logic             step_pulse;
   logic             done;
   logic             busy;
   logic [CNT_W-1:0] steps_left;
`ifdef JSEQ_ABORT_EN
   logic             abort;
   logic             aborted;
`endif

   int checks = 0;
   int errors = 0;
   int pos    = 0;
   int ncmd   = 0;

   johnson_step_sequencer #(.WIDTH(W), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_steps  (cmd_steps),
      .cmd_period (cmd_period),
      .out_j      (out_j),
      .step_pulse (step_pulse),
      .done       (done),
      .busy       (busy),
`ifdef JSEQ_ABORT_EN
      .abort      (abort),
      .aborted    (aborted),
`endif
      .steps_left (steps_left)
   );

   always #5 clk = ~clk;

   // Johnson pattern at position p: first W positions fill ones from the LSB,
   // the next W positions clear them from the LSB.
   function automatic logic [W-1:0] pat(input int p);
      int q;
      logic [31:0] t;
      q = ((p % (2*W)) + 2*W) % (2*W);
      if (q <= W) t = (32'd1 << q) - 32'd1;
      else        t = ~((32'd1 << (q - W)) - 32'd1);
      return t[W-1:0];
   endfunction

   // Issue one command and check every cycle up to stop_after cycles
   task automatic run_cmd(input logic d, input int n, input int p,
                          input bit hold, input int stop_after, input string tag);
      int total;
      int last;
      int exp_left;
      bit exp_step;
      bit exp_done;
      ncmd++;
      $display("cmd %0d [%s]: dir=%0d steps=%0d period=%0d hold=%0d", ncmd, tag, d, n, p, hold);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_before_cmd got %b exp 1", tag, cmd_ready);
      end
      cmd_valid  = 1'b1;
      cmd_dir    = d;
      cmd_steps  = CNT_W'(n);
      cmd_period = DIV_W'(p);
      @(posedge clk); #1;
      if (!hold || n == 0) cmd_valid = 1'b0;
      if (n == 0) begin
         checks++;
         if (done !== 1'b1 || step_pulse !== 1'b0 || cmd_ready !== 1'b1 || out_j !== pat(pos)) begin
            errors++;
            $display("FAIL %s zero_accept got done=%b sp=%b rdy=%b out=%b exp done=1 sp=0 rdy=1 out=%b",
                     tag, done, step_pulse, cmd_ready, out_j, pat(pos));
         end
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || step_pulse !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s zero_after got done=%b sp=%b rdy=%b exp 0 0 1", tag, done, step_pulse, cmd_ready);
         end
         return;
      end
      total = n * (p + 1);
      last  = (stop_after < total) ? stop_after : total;
      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #1;
         exp_step = ((c % (p + 1)) == 0);
         if (exp_step) pos += d ? 1 : -1;
         exp_left = n - c / (p + 1);
         exp_done = (c == total);
         checks++;
         if (step_pulse !== exp_step) begin
            errors++;
            $display("FAIL %s step_pulse c=%0d got %b exp %b", tag, c, step_pulse, exp_step);
         end
         checks++;
         if (out_j !== pat(pos)) begin
            errors++;
            $display("FAIL %s out_j c=%0d got %b exp %b", tag, c, out_j, pat(pos));
         end
         checks++;
         if (steps_left !== CNT_W'(exp_left)) begin
            errors++;
            $display("FAIL %s steps_left c=%0d got %0d exp %0d", tag, c, steps_left, exp_left);
         end
         checks++;
         if (done !== exp_done) begin
            errors++;
            $display("FAIL %s done c=%0d got %b exp %b", tag, c, done, exp_done);
         end
         checks++;
         if (cmd_ready !== exp_done || busy !== !exp_done) begin
            errors++;
            $display("FAIL %s ready_busy c=%0d got rdy=%b busy=%b exp rdy=%b", tag, c, cmd_ready, busy, exp_done);
         end
         if (hold) begin
            if (c == total) begin
               cmd_valid = 1'b0;
            end else begin
               cmd_dir    = 1'($urandom);
               cmd_period = DIV_W'($urandom);
               cmd_steps  = CNT_W'($urandom);
            end
         end
      end
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      pos = 0;
      checks++;
      if (out_j !== '0 || steps_left !== '0 || done !== 1'b0 || step_pulse !== 1'b0 ||
          cmd_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got out=%b left=%0d done=%b sp=%b rdy=%b busy=%b exp 0000 0 0 0 1 0",
                  out_j, steps_left, done, step_pulse, cmd_ready, busy);
      end
      $display("reset applied");
   endtask

   task automatic test_forward_full();
      run_cmd(1'b1, 8, 0, 1'b0, 1000, "fwd8_p0");
      checks++;
      if (out_j !== 4'b0000) begin
         errors++;
         $display("FAIL fwd8_final got %b exp 0000", out_j);
      end
   endtask

   task automatic test_back_to_back();
      run_cmd(1'b1, 3, 4, 1'b0, 1000, "fwd3_p4");
      checks++;
      if (out_j !== 4'b0111) begin
         errors++;
         $display("FAIL fwd3_final got %b exp 0111", out_j);
      end
      run_cmd(1'b0, 3, 4, 1'b0, 1000, "rev3_p4");
      checks++;
      if (out_j !== 4'b0000) begin
         errors++;
         $display("FAIL rev3_final got %b exp 0000", out_j);
      end
   endtask

   task automatic test_zero_steps();
      run_cmd(1'b1, 0, 5, 1'b0, 1000, "zero");
   endtask

   task automatic test_hold_midrun();
      run_cmd(1'b1, 10, 2, 1'b1, 1000, "hold10_p2");
      checks++;
      if (out_j !== 4'b0011) begin
         errors++;
         $display("FAIL hold10_final got %b exp 0011", out_j);
      end
      @(posedge clk); #1;
      checks++;
      if (cmd_ready !== 1'b1 || step_pulse !== 1'b0) begin
         errors++;
         $display("FAIL hold10_no_reaccept got rdy=%b sp=%b exp 1 0", cmd_ready, step_pulse);
      end
   endtask

   task automatic test_reset_midrun();
      run_cmd(1'b1, 10, 1, 1'b0, 6, "rst_mid");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      pos = 0;
      checks++;
      if (out_j !== '0 || steps_left !== '0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state got out=%b left=%0d rdy=%b done=%b exp 0000 0 1 0",
                  out_j, steps_left, cmd_ready, done);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || out_j !== '0) begin
         errors++;
         $display("FAIL rst_mid_after got done=%b out=%b exp 0 0000", done, out_j);
      end
      $display("reset mid-run applied");
   endtask

`ifdef JSEQ_ABORT_EN
   task automatic test_abort();
      // Three cycles in, the divider has expired and the first step is due
      run_cmd(1'b1, 5, 3, 1'b0, 3, "abort5");
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (step_pulse !== 1'b0 || aborted !== 1'b1 || steps_left !== CNT_W'(5) ||
          done !== 1'b0 || cmd_ready !== 1'b1 || out_j !== pat(pos)) begin
         errors++;
         $display("FAIL abort_due got sp=%b ab=%b left=%0d done=%b rdy=%b out=%b exp 0 1 5 0 1 %b",
                  step_pulse, aborted, steps_left, done, cmd_ready, out_j, pat(pos));
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checks++;
      if (aborted !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got ab=%b rdy=%b done=%b exp 0 1 0", aborted, cmd_ready, done);
      end
      $display("abort applied");
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         run_cmd(1'($urandom), int'($urandom_range(12, 0)), int'($urandom_range(3, 0)),
                 1'($urandom), 1000, "rand");
      end
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_dir    = 1'b0;
      cmd_steps  = '0;
      cmd_period = '0;
`ifdef JSEQ_ABORT_EN
      abort      = 1'b0;
`endif
      test_reset();
      test_forward_full();
      test_back_to_back();
      test_zero_steps();
      test_hold_midrun();
      test_reset_midrun();
`ifdef JSEQ_ABORT_EN
      test_abort();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
